// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned operands.
//
// The operands are converted to magnitudes when a request is accepted. The
// block then makes one shift-add step per cycle for WIDTH cycles and applies
// the result sign when it loads the output register.
//
// Parameters:
//   WIDTH       operand width in bits; the product is 2*WIDTH bits
// Ports:
//   clk_i       system clock; all state changes on the rising edge
//   rst_i       asynchronous active-low reset
//   start_i     request to begin a multiply; sampled only in idle
//   signed_i    1 = two's-complement operands, 0 = unsigned (sampled with start_i)
//   src1_i      multiplicand (sampled with start_i)
//   src2_i      multiplier (sampled with start_i)
//   busy_o      high whenever the FSM is not idle
//   done_o      one-cycle pulse; result_o has just been loaded
//   result_o    product {hi, lo}; held until the next completed multiply
//   result_lo_o low WIDTH bits of result_o
//   zero_o      high when result_o is zero
module seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     src1_i,
    input  logic [WIDTH-1:0]     src2_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic [WIDTH-1:0]     result_lo_o,
    output logic                 zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_t;

    state_t               state_q, state_d;
    logic                 signed_q, signed_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 src1_neg, src2_neg;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [2*WIDTH-1:0]   acc_step;

    // Negating the most negative value yields 2^(WIDTH-1), which is the
    // correct magnitude when read as unsigned.
    assign src1_neg = signed_i & src1_i[WIDTH-1];
    assign src2_neg = signed_i & src2_i[WIDTH-1];
    assign mag1     = src1_neg ? -src1_i : src1_i;
    assign mag2     = src2_neg ? -src2_i : src2_i;

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        signed_d = signed_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    signed_d = signed_i;
                    neg_d    = src1_neg ^ src2_neg;
                    mcand_d  = {{WIDTH{1'b0}}, mag1};
                    mplier_d = mag2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    result_d = (signed_q && neg_q) ? -acc_step : acc_step;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            signed_q <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            signed_q <= signed_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign result_o    = result_q;
    assign result_lo_o = result_q[WIDTH-1:0];
    assign zero_o      = (result_q == '0);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH = 32).
module tb_seq_multiplier;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          signed_i;
    logic [W-1:0]  src1_i;
    logic [W-1:0]  src2_i;
    logic          busy_o;
    logic          done_o;
    logic [2*W-1:0] result_o;
    logic [W-1:0]  result_lo_o;
    logic          zero_o;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int exp_done_cnt = 0;
    logic [2*W-1:0] exp_q[$];

    seq_multiplier #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .result_lo_o(result_lo_o),
        .zero_o     (zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Counts done pulses (each is one cycle wide).
    always @(negedge clk_i) begin
        if (done_o === 1'b1) done_cnt++;
    end

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic [2*W-1:0] ea, eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge in idle; returns #1 after the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        start_i  = 1'b1;
        src1_i   = a;
        src2_i   = b;
        signed_i = s;
        exp_q.push_back(model(a, b, s));
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        // Operands become don't-care once accepted.
        src1_i   = $urandom;
        src2_i   = $urandom;
        signed_i = ~s;
        check("busy_after_accept", 64'(busy_o), 64'd1);
    endtask

    // Waits for done, counting edges since the accept edge; checks latency,
    // the scoreboard entry, and the following idle cycle.
    task automatic wait_done(input string tag, input int elapsed);
        int lat;
        logic [2*W-1:0] exp;
        lat = 0;
        for (int e = elapsed + 1; e <= 40; e++) begin
            @(posedge clk_i);
            #1;
            if (done_o === 1'b1) begin
                lat = e;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(W));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (lat != 0) begin
            exp_done_cnt++;
            check({tag, "_result"}, result_o, exp);
            check({tag, "_result_lo"}, 64'(result_lo_o), 64'(exp[W-1:0]));
            check({tag, "_zero"}, 64'(zero_o), 64'(exp == '0));
            check({tag, "_busy_in_done"}, 64'(busy_o), 64'd1);
            @(posedge clk_i);
            #1;
            check({tag, "_done_single"}, 64'(done_o), 64'd0);
            check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
            check({tag, "_held"}, result_o, exp);
        end
    endtask

    initial begin
        rst_i    = 1'b0;
        start_i  = 1'b0;
        signed_i = 1'b0;
        src1_i   = '0;
        src2_i   = '0;
        #2;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_zero", 64'(zero_o), 64'd1);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed products; each start lands in the first idle cycle after
        // the previous done, so these also run back-to-back.
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("umax", 0);
        check("umax_const", result_o, 64'hFFFF_FFFE_0000_0001);
        start_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
        wait_done("neg3x7", 0);
        check("neg3x7_const", result_o, 64'hFFFF_FFFF_FFFF_FFEB);
        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("minsq_s", 0);
        check("minsq_s_const", result_o, 64'h4000_0000_0000_0000);
        start_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done("minsq_u", 0);
        start_op(32'h1234_5678, 32'h0000_0000, 1'b0);
        wait_done("zero_op", 0);
        start_op(32'h7FFF_FFFF, 32'h8000_0001, 1'b1);
        wait_done("mixed_s", 0);
        start_op($urandom, $urandom, 1'b1);
        wait_done("rand_s", 0);
        start_op($urandom, $urandom, 1'b0);
        wait_done("rand_u", 0);

        // Request mid-calc must be ignored and not queued.
        start_op(32'd1000, 32'd77, 1'b0);
        repeat (5) @(posedge clk_i);
        #1;
        start_i  = 1'b1;
        src1_i   = 32'd3;
        src2_i   = 32'd4;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        wait_done("ignored_req", 6);
        repeat (38) @(posedge clk_i);
        #1;
        check("no_queued_pulse", 64'(done_cnt), 64'(exp_done_cnt));

        // Reset abort during calc.
        start_op(32'd7, 32'd9, 1'b0);
        repeat (9) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_result", result_o, 64'd0);
        check("abort_zero", 64'(zero_o), 64'd1);
        check("abort_done", 64'(done_o), 64'd0);
        void'(exp_q.pop_front());
        start_i  = 1'b1;
        signed_i = 1'b0;
        src1_i   = 32'd5;
        src2_i   = 32'd6;
        exp_q.push_back(64'd30);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done("after_abort", 0);
        check("after_abort_const", result_o, 64'd30);

        repeat (40) @(posedge clk_i);
        #1;
        check("done_pulse_count", 64'(done_cnt), 64'(exp_done_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; the product is 2*WIDTH bits.
REQ-002 Port: clk_i  input  1  system clock, all state changes on the rising edge.
REQ-003 Port: rst_i  input  1  reset; asynchronous, active-low.
REQ-004 Port: start_i  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 Port: signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
REQ-006 Port: src1_i  input  WIDTH  multiplicand; sampled with start_i.
REQ-007 Port: src2_i  input  WIDTH  multiplier; sampled with start_i.
REQ-008 Port: busy_o  output  1  high whenever state is not IDLE.
REQ-009 Port: done_o  output  1  single-cycle pulse marking result_o as newly valid.
REQ-010 Port: result_o  output  2*WIDTH  product; {hi, lo}.
REQ-011 Port: result_lo_o  output  WIDTH  result_o[WIDTH-1:0], for the 32-bit ALU result path.
REQ-012 Port: zero_o  output  1  high when result_o equals 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 In IDLE with start_i=1 at a rising edge, the block SHALL latch signed_i, the operand magnitudes and the result sign, clear the accumulator and the iteration counter, and enter CALC.
REQ-015 Operand magnitude: when signed_i=1 and the operand MSB is 1, the magnitude SHALL be the two's-complement negation; otherwise it SHALL be the raw value. -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
REQ-016 Result sign SHALL be src1_i[MSB] XOR src2_i[MSB] when signed_i=1, and 0 otherwise.
REQ-017 CALC SHALL perform one radix-2 shift-add step per cycle: if the current multiplier bit is 1, add the shifted multiplicand into the 2*WIDTH accumulator; then advance the counter.
REQ-018 CALC SHALL last exactly WIDTH cycles; on the edge that completes step WIDTH, the FSM SHALL enter DONE and load result_o with the accumulator, negated mod 2^(2*WIDTH) when the result sign is 1.
REQ-019 done_o SHALL be high only while in DONE, for exactly one cycle, beginning WIDTH edges after the edge that accepted start_i (32 edges at default).
REQ-020 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-021 start_i SHALL be ignored in CALC and DONE; no request is queued.
REQ-022 A new start_i is accepted in the first IDLE cycle after DONE, giving a back-to-back throughput of one result per WIDTH+2 cycles.
REQ-023 Operand inputs SHALL be don't-care after the accept edge; changes to them SHALL NOT affect the product in flight.
REQ-024 result_o, result_lo_o and zero_o SHALL hold their last value from the DONE load until the next DONE load.
REQ-025 Arithmetic SHALL be exact modulo 2^(2*WIDTH); overflow is not possible and no overflow flag is produced.

Reset
REQ-026 rst_i=0 SHALL immediately force IDLE and clear the accumulator, counter, result_o and done_o to 0, with busy_o=0 and zero_o=1.
REQ-027 Reset asserted in CALC or DONE SHALL abort the operation; no done_o pulse is produced for the aborted request.
REQ-028 The first start_i SHALL be honoured on the first rising edge after rst_i returns high.

Verification
REQ-029 Unsigned: src1=0xFFFFFFFF, src2=0xFFFFFFFF, signed_i=0 -> result_o=0xFFFFFFFE_00000001, done_o pulse exactly 32 edges after accept.
REQ-030 Signed: src1=0xFFFFFFFD (-3), src2=0x00000007, signed_i=1 -> result_o=0xFFFFFFFF_FFFFFFEB (-21), result_lo_o=0xFFFFFFEB, zero_o=0.
REQ-031 Signed corner case: src1=src2=0x80000000, signed_i=1 -> result_o=0x40000000_00000000; with signed_i=0 -> the same value.
REQ-032 Zero operand: src1=0x12345678, src2=0 -> result_o=0, zero_o=1, latency unchanged at 32 edges.
REQ-033 Ignored request: pulse start_i with new operands in mid-CALC -> first result unchanged, exactly one done_o pulse; back-to-back start in the IDLE cycle after DONE is accepted.
REQ-034 Reset abort: assert rst_i at cycle 10 of CALC -> busy_o=0 and result_o=0 immediately, no done_o pulse; after release, 5*6 completes with result_o=30.
